// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C register-write initiator
package i2c_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    STOP,
    DONE
  } state_t;

  // Quarter phase within one SCL period
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } qphase_t;

  // Responder register map: three cmpa bytes plus a commit strobe
  localparam logic [7:0] REG_CMP_B0     = 8'd0;
  localparam logic [7:0] REG_CMP_B1     = 8'd1;
  localparam logic [7:0] REG_CMP_B2     = 8'd2;
  localparam logic [7:0] REG_CMP_COMMIT = 8'd3;

endpackage

// File: rtl/i2c_sync2.sv
// rtl/i2c_sync2.sv - two-flop synchronizer for an I2C pad level
module i2c_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk1d,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two back-to-back flops; reset to the idle (released, high) bus level
  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/i2c_reg_master.sv
// rtl/i2c_reg_master.sv - I2C initiator writing one byte to one responder register (option: I2CM_STRETCH_EN)
module i2c_reg_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2A,
  parameter int         REGBITS  = 3,
  parameter int         QDIV     = 5
) (
  input  logic               clk1d,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [REGBITS-1:0] cmd_addr,
  input  logic [7:0]         cmd_data,
  output logic               busy,
  output logic               done,
  output logic               nack,
  output logic               scl_oe,
  input  logic               scl_in,
  output logic               sda_oe,
  input  logic               sda_in
);

  localparam logic [7:0] QLOAD = 8'(QDIV - 1);

  state_t               r_state;
  qphase_t              r_q;
  logic [7:0]           r_qcnt;
  logic [7:0]           r_sh;
  logic [2:0]           r_bit;
  logic [1:0]           r_byte;
  logic [REGBITS-1:0]   r_addr;
  logic [7:0]           r_data;
  logic                 r_nack;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_nack_o;
  logic                 r_scl_oe;
  logic                 r_sda_oe;

  logic                 w_sda_s;
  logic                 w_freeze;
  logic                 w_tick;
  logic [7:0]           w_byte1;
  logic [7:0]           w_next_byte;

  i2c_sync2 u_sync_sda (
    .clk1d (clk1d),
    .rst   (rst),
    .i_d   (sda_in),
    .o_q   (w_sda_s)
  );

`ifdef I2CM_STRETCH_EN
  logic w_scl_s;

  i2c_sync2 u_sync_scl (
    .clk1d (clk1d),
    .rst   (rst),
    .i_d   (scl_in),
    .o_q   (w_scl_s)
  );

  // A responder holding SCL low after we released it stalls the clock high phase
  assign w_freeze = ((r_state == BIT) || (r_state == ACK)) && (r_q == Q2) && !w_scl_s;
`else
  logic w_unused_scl;

  assign w_unused_scl = scl_in;
  assign w_freeze     = 1'b0;
`endif

  assign w_tick      = (r_qcnt == 8'd0) && !w_freeze;
  assign w_byte1     = 8'(r_addr);
  assign w_next_byte = (r_byte == 2'd0) ? w_byte1 : r_data;

  // Quarter-period divider: parked at reload while idle, counts down during a frame
  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      r_qcnt <= QLOAD;
    end else if ((r_state == IDLE) || (r_state == DONE)) begin
      r_qcnt <= QLOAD;
    end else if (w_freeze) begin
      r_qcnt <= r_qcnt;
    end else if (r_qcnt == 8'd0) begin
      r_qcnt <= QLOAD;
    end else begin
      r_qcnt <= r_qcnt - 8'd1;
    end
  end

  // Frame sequencer; line drives are set on entry to each quarter phase
  always_ff @(posedge clk1d or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_q      <= Q0;
      r_sh     <= 8'd0;
      r_bit    <= 3'd0;
      r_byte   <= 2'd0;
      r_addr   <= '0;
      r_data   <= 8'd0;
      r_nack   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_nack_o <= 1'b0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_nack_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr   <= cmd_addr;
            r_data   <= cmd_data;
            r_sh     <= {DEV_ADDR, 1'b0};
            r_bit    <= 3'd7;
            r_byte   <= 2'd0;
            r_nack   <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= START;
            r_q      <= Q0;
            r_sda_oe <= 1'b1;
            r_scl_oe <= 1'b0;
          end
        end
        // q0 pulls SDA with SCL high; q1..q3 hold SCL low so START fills a full bit slot
        START: begin
          if (w_tick) begin
            case (r_q)
              Q0: begin
                r_q      <= Q1;
                r_scl_oe <= 1'b1;
              end
              Q1: r_q <= Q2;
              Q2: r_q <= Q3;
              default: begin
                r_state  <= BIT;
                r_q      <= Q0;
                r_sda_oe <= ~r_sh[7];
              end
            endcase
          end
        end
        BIT: begin
          if (w_tick) begin
            case (r_q)
              Q0: r_q <= Q1;
              Q1: begin
                r_q      <= Q2;
                r_scl_oe <= 1'b0;
              end
              Q2: r_q <= Q3;
              default: begin
                r_q      <= Q0;
                r_scl_oe <= 1'b1;
                if (r_bit == 3'd0) begin
                  r_state  <= ACK;
                  r_sda_oe <= 1'b0;
                end else begin
                  r_bit    <= r_bit - 3'd1;
                  r_sh     <= {r_sh[6:0], 1'b0};
                  r_sda_oe <= ~r_sh[6];
                end
              end
            endcase
          end
        end
        ACK: begin
          if (w_tick) begin
            case (r_q)
              Q0: r_q <= Q1;
              Q1: begin
                r_q      <= Q2;
                r_scl_oe <= 1'b0;
              end
              Q2: r_q <= Q3;
              default: begin
                r_q      <= Q0;
                r_scl_oe <= 1'b1;
                if (w_sda_s) begin
                  r_nack   <= 1'b1;
                  r_state  <= STOP;
                  r_sda_oe <= 1'b1;
                end else if (r_byte == 2'd2) begin
                  r_state  <= STOP;
                  r_sda_oe <= 1'b1;
                end else begin
                  r_state  <= BIT;
                  r_byte   <= r_byte + 2'd1;
                  r_bit    <= 3'd7;
                  r_sh     <= w_next_byte;
                  r_sda_oe <= ~w_next_byte[7];
                end
              end
            endcase
          end
        end
        // SCL rises first, then SDA; q3 is bus-free hold before reporting
        STOP: begin
          if (w_tick) begin
            case (r_q)
              Q0: begin
                r_q      <= Q1;
                r_scl_oe <= 1'b0;
              end
              Q1: begin
                r_q      <= Q2;
                r_sda_oe <= 1'b0;
              end
              Q2: r_q <= Q3;
              default: begin
                r_state  <= DONE;
                r_q      <= Q0;
                r_done   <= 1'b1;
                r_nack_o <= r_nack;
              end
            endcase
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state  <= IDLE;
          r_ready  <= 1'b1;
          r_scl_oe <= 1'b0;
          r_sda_oe <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = ~r_ready;
  assign done      = r_done;
  assign nack      = r_nack_o;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

endmodule

// File: doc/i2c_reg_master.md
Name: i2c_reg_master

Overview:
- I2C initiator that writes one 8-bit value into one register of a remote i2cregif-style responder per command.
- Sits on a controller/test board FPGA, or on a second PWM board, and drives cmpa byte loads (reg 0..2) and the commit strobe (reg 3) over I2C.
- Runs in the clk1d domain.
- Open-drain pad handling stays outside the block (BBPU): oe=1 pulls the line low; oe=0 releases it.

Parameters:
- DEV_ADDR, 7'h2A, 7-bit I2C address of the target responder.
- REGBITS, 3, width of the register address field.
- QDIV, 5, clk1d cycles per SCL quarter-period; legal range 2..255. SCL period = 4*QDIV cycles.

Ports:
- clk1d  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  write request.
- cmd_ready  out  1  block can accept a command (IDLE).
- cmd_addr  in  REGBITS  target register address.
- cmd_data  in  8  data byte.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at end of transaction.
- nack  out  1  one-cycle pulse, coincident with done, when any byte was NACKed.
- scl_oe  out  1  1 = drive SCL low.
- scl_in  in  1  SCL pad level.
- sda_oe  out  1  1 = drive SDA low.
- sda_in  in  1  SDA pad level.

Behaviour:
- Reset values: scl_oe=0, sda_oe=0, cmd_ready=1, busy=0, done=0, nack=0; state=IDLE.
- Reset asserted mid-transaction releases both lines within the same cycle. No STOP is generated; the responder recovers on its next START.
- scl_in and sda_in pass through a 2-flop synchronizer before use (2 cycles of latency).
- Handshake:
  - Command accepted when cmd_valid && cmd_ready.
  - cmd_addr and cmd_data are registered on acceptance.
  - cmd_ready=0 from the next cycle until the cycle after done.
  - busy = !cmd_ready.
- Frame per command: START, byte0 = {DEV_ADDR, 1'b0}, ACK, byte1 = {zero pad, cmd_addr} (8 bits), ACK, byte2 = cmd_data, ACK, STOP. Bytes are sent MSB first.
- Quarter-tick counter reloads at QDIV-1 and runs only outside IDLE. Each state advances on tick.
- States:
  - IDLE: both lines released.
  - START: q0 SDA low with SCL released; q1 SCL low.
  - BIT: q0 SCL low, set SDA = ~bit; q1 SCL low; q2 release SCL; q3 SCL high, sample nothing. After bit 0, go to ACK.
  - ACK: SDA released; SCL cycles as in BIT; sample the synchronized sda_in at the end of q3. A high sample is a NACK: set the nack flag and go to STOP. Otherwise go to the next byte, or to STOP after byte2.
  - STOP: q0 SCL low, SDA low; q1 release SCL; q2 release SDA; q3 hold (bus-free time).
  - DONE: pulse done, plus nack if flagged, for one cycle, then return to IDLE.
- Command acceptance to done = (1 + 27 + 1) * 4 * QDIV + small constant cycles; the exact constant is fixed in the implementation and checked in test.
- Arbitration loss is not detected (single master).
- cmd_valid asserted while busy is ignored; the requester must hold it.

Optional Feature:
- Macro I2CM_STRETCH_EN.
- Defined: in q2 of BIT and ACK, the quarter counter freezes while the synchronized scl_in is low (the responder is stretching). Counting resumes in the cycle after scl_in is seen high.
- Undefined: scl_in is unused, SCL timing is purely open-loop, and synthesis removes the synchronizer flop for scl_in.

Decomposition:
- Package i2c_pkg:
  - State enum {IDLE, START, BIT, ACK, STOP, DONE}.
  - Register address constants REG_CMP_B0=0, REG_CMP_B1=1, REG_CMP_B2=2, REG_CMP_COMMIT=3.
  - Quarter-phase enum.
- One sub-module, i2c_sync2: the 2-flop synchronizer, instantiated for sda_in and scl_in.

Test Plan:
- ACK path: bench responder model at address 0x2A; command addr=1, data=0xA0 -> bytes 0x54, 0x01, 0xA0 observed MSB first; START and STOP correct; done=1, nack=0; cmd_ready returns 1 one cycle after done.
- Address NACK: model at 0x2B; any command -> SDA released after byte0, STOP issued, done and nack pulse together; byte1 never sent.
- Full cmpa load: commands (0,0x03), (1,0x00), (2,0xA0), (3,0x00) back-to-back -> four complete frames; the model's cmpa reads {0xA0, 0x00, 0x03} after the commit.
- Mid-frame reset: assert rst during bit 3 of byte1 -> scl_oe=0, sda_oe=0 in the same cycle; after release, cmd_ready=1 and the next command completes normally.
- Stretch (I2CM_STRETCH_EN): model holds SCL low for 37 cycles during the byte2 ACK -> q2 extends by 37 cycles plus sync latency, no bit is corrupted, done is delayed by the same amount.
- QDIV=2 corner: command addr=7, data=0xFF -> SCL period is 8 cycles throughout; frame decodes correctly.
